// File: rtl/cursor_motion_ctrl.sv
// cursor_motion_ctrl: held direction switches -> clamped (x,y) cursor, updates on move-tick edges.
// Build option CURSOR_WRAP_EN: edges wrap around instead of saturating.
module cursor_motion_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int SIZE0       = 4,
  parameter int SIZE1       = 8,
  parameter int SIZE2       = 20,
  parameter int SIZE3       = 32,
  parameter int TICK_DIV    = 1,
  parameter int ACCEL_TICKS = 16,
  parameter int FAST_STEP   = 4,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cursor_size,
  input  logic          sw_up,
  input  logic          sw_down,
  input  logic          sw_left,
  input  logic          sw_right,
  input  logic          recentre,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          moving,
  output logic [3:0]    at_edge
);

  localparam int PW = (XW > YW) ? XW : YW;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(ACCEL_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [XW-1:0] r_x, w_x_nxt, w_max_x, w_init_x, w_x_mv;
  logic [YW-1:0] r_y, w_y_nxt, w_max_y, w_init_y, w_y_mv;
  logic [PW-1:0] w_size, w_step;
  logic          w_tick, w_any_sw;

  // One axis step; opposing switches cancel. Sum is one bit wider so it cannot overflow.
  function automatic logic [PW-1:0] f_move(input logic [PW-1:0] pos, input logic [PW-1:0] maxv,
                                           input logic [PW-1:0] step, input logic inc, input logic dec);
    logic [PW:0] sum;
    sum    = {1'b0, pos} + {1'b0, step};
    f_move = pos;
    if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
      f_move = (sum > {1'b0, maxv}) ? '0 : sum[PW-1:0];
`else
      f_move = (sum > {1'b0, maxv}) ? maxv : sum[PW-1:0];
`endif
    end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
      f_move = (pos >= step) ? pos - step : maxv;
`else
      f_move = (pos >= step) ? pos - step : '0;
`endif
    end
  endfunction

  always_comb begin
    w_size = PW'(SIZE0);
    case (cursor_size)
      2'd1:    w_size = PW'(SIZE1);
      2'd2:    w_size = PW'(SIZE2);
      2'd3:    w_size = PW'(SIZE3);
      default: w_size = PW'(SIZE0);
    endcase
  end

  assign w_max_x  = XW'(SCREEN_W) - w_size[XW-1:0];
  assign w_max_y  = YW'(SCREEN_H) - w_size[YW-1:0];
  assign w_init_x = (XW'(INIT_X) > w_max_x) ? w_max_x : XW'(INIT_X);
  assign w_init_y = (YW'(INIT_Y) > w_max_y) ? w_max_y : YW'(INIT_Y);
  assign w_tick   = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_any_sw = sw_up | sw_down | sw_left | sw_right;
  assign w_step   = (r_state == FAST) ? PW'(FAST_STEP) : PW'(1);
  assign w_x_mv   = XW'(f_move(PW'(r_x), PW'(w_max_x), w_step, sw_right, sw_left));
  assign w_y_mv   = YW'(f_move(PW'(r_y), PW'(w_max_y), w_step, sw_down, sw_up));

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (recentre || !w_any_sw) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = SLOW;
        SLOW: if (w_tick) begin
          if (r_hold == HW'(ACCEL_TICKS - 1)) begin
            w_state_nxt = FAST;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        default: w_state_nxt = FAST;
      endcase
    end
  end

  // Re-clamp outranks movement so a size increase never leaves the cursor off-screen.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (recentre) begin
      w_x_nxt = w_init_x;
      w_y_nxt = w_init_y;
    end else begin
      if (r_x > w_max_x)  w_x_nxt = w_max_x;
      else if (w_tick)    w_x_nxt = w_x_mv;
      if (r_y > w_max_y)  w_y_nxt = w_max_y;
      else if (w_tick)    w_y_nxt = w_y_mv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_tick_cnt <= '0;
      r_x        <= XW'(INIT_X);
      r_y        <= YW'(INIT_Y);
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
    end
  end

  assign cursor_x = r_x;
  assign cursor_y = r_y;
  assign moving   = (r_state != IDLE);
  assign at_edge  = {r_y == w_max_y, r_y == '0, r_x == w_max_x, r_x == '0};

endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Scoreboard bench for cursor_motion_ctrl: stimulus queues expected outputs per cycle, monitor compares.
module tb_cursor_motion_ctrl;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cursor_size;
  logic       sw_up, sw_down, sw_left, sw_right, recentre;
  logic [9:0] cursor_x, cursor_y;
  logic       moving;
  logic [3:0] at_edge;

  logic [1:0] size4;
  logic       up4, down4, left4, right4, rc4;
  logic [9:0] x4, y4;
  logic       mov4;
  logic [3:0] edge4;

  always #5 clk = ~clk;

  cursor_motion_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cursor_size(cursor_size),
    .sw_up(sw_up), .sw_down(sw_down), .sw_left(sw_left), .sw_right(sw_right),
    .recentre(recentre), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .moving(moving), .at_edge(at_edge)
  );

  cursor_motion_ctrl #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cursor_size(size4),
    .sw_up(up4), .sw_down(down4), .sw_left(left4), .sw_right(right4),
    .recentre(rc4), .cursor_x(x4), .cursor_y(y4),
    .moving(mov4), .at_edge(edge4)
  );

  typedef struct {
    int         tgt;
    string      nm;
    int         x;
    int         y;
    bit         mov;
    logic [3:0] edg;
    logic [3:0] mask;   // [0]=x [1]=y [2]=moving [3]=at_edge
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input string nm, input int ex, input int ey, input bit em,
                      input logic [3:0] ee, input logic [3:0] m);
    exp_t e;
    e.tgt = cyc + 1; e.nm = nm; e.x = ex; e.y = ey; e.mov = em; e.edg = ee; e.mask = m;
    q.push_back(e);
  endtask

  // Monitor: outputs are registered, so sample 1 ns after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      if (e.tgt < cyc) check({"missed ", e.nm}, cyc, e.tgt);
      else begin
        if (e.mask[0]) check({e.nm, " x"}, int'(cursor_x), e.x);
        if (e.mask[1]) check({e.nm, " y"}, int'(cursor_y), e.y);
        if (e.mask[2]) check({e.nm, " moving"}, int'(moving), int'(e.mov));
        if (e.mask[3]) check({e.nm, " at_edge"}, int'(at_edge), int'(e.edg));
      end
    end
    while (q4.size() > 0 && q4[0].tgt <= cyc) begin
      e = q4.pop_front();
      if (e.tgt < cyc) check({"missed ", e.nm}, cyc, e.tgt);
      else begin
        check({e.nm, " x"}, int'(x4), e.x);
        check({e.nm, " moving"}, int'(mov4), int'(e.mov));
      end
    end
  end

  initial begin
    int rel;
    rst_n = 1'b0; cursor_size = 2'd0; recentre = 1'b0;
    sw_up = 1'b0; sw_down = 1'b0; sw_left = 1'b0; sw_right = 1'b0;
    size4 = 2'd0; up4 = 1'b0; down4 = 1'b0; right4 = 1'b0; rc4 = 1'b0; left4 = 1'b1;
    repeat (2) @(negedge clk);
    push("reset", 320, 240, 1'b0, 4'b0000, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    // TICK_DIV=4 instance: left held from reset, moves only on every 4th edge.
    for (int k = 1; k <= 12; k++) begin
      exp_t e;
      e.tgt = rel + k; e.nm = "div4"; e.x = 320 - k / 4; e.y = 240; e.mov = 1'b1;
      e.edg = 4'b0000; e.mask = 4'b0101;
      q4.push_back(e);
    end

    // Acceleration: 17 single steps (IDLE + 16 SLOW ticks), then +4 per clock.
    sw_right = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      push("accel", (k <= 17) ? 320 + k : 337 + 4 * (k - 17), 240, 1'b1, 4'b0000, 4'b0101);
      @(negedge clk);
    end
    sw_right = 1'b0; push("release", 349, 240, 1'b0, 4'b0000, 4'b0101); @(negedge clk);
    sw_right = 1'b1; push("repress", 350, 240, 1'b1, 4'b0000, 4'b0101); @(negedge clk);
    sw_right = 1'b0; push("idle", 350, 240, 1'b0, 4'b0000, 4'b0101); @(negedge clk);

    sw_up = 1'b1; sw_right = 1'b1; push("diag", 351, 239, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    sw_up = 1'b0; sw_right = 1'b0; push("diag_rel", 351, 239, 1'b0, 4'b0000, 4'b1111); @(negedge clk);
    sw_down = 1'b1; push("down", 351, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    sw_down = 1'b0; push("down_rel", 351, 240, 1'b0, 4'b0000, 4'b1111); @(negedge clk);

    // Saturate at size 0 right edge, then grow the cursor with right still held.
    sw_right = 1'b1;
    repeat (100) @(negedge clk);
    push("sat_636", 636, 240, 1'b1, 4'b0010, 4'b1111); @(negedge clk);
    cursor_size = 2'd2; push("reclamp", 620, 240, 1'b1, 4'b0010, 4'b1111); @(negedge clk);
    sw_right = 1'b0; push("reclamp_rel", 620, 240, 1'b0, 4'b0010, 4'b1111); @(negedge clk);

    sw_left = 1'b1;
    push("left619", 619, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    push("left618", 618, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    sw_left = 1'b0; push("left_rel", 618, 240, 1'b0, 4'b0000, 4'b1111); @(negedge clk);
    sw_right = 1'b1;
    push("right619", 619, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    push("right620", 620, 240, 1'b1, 4'b0010, 4'b1111); @(negedge clk);
    push("right_sat", 620, 240, 1'b1, 4'b0010, 4'b1111); @(negedge clk);
    sw_right = 1'b0; push("right_rel", 620, 240, 1'b0, 4'b0010, 4'b1111); @(negedge clk);

    sw_up = 1'b1; sw_down = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      push("updown", 620, 240, 1'b1, 4'b0010, 4'b0111);
      @(negedge clk);
    end
    sw_up = 1'b0; sw_down = 1'b0; push("updown_rel", 620, 240, 1'b0, 4'b0010, 4'b1111); @(negedge clk);

    // 17 single steps to 603 then 150 fast steps lands exactly on 3 in either build.
    sw_left = 1'b1;
    repeat (166) @(negedge clk);
    push("left_run", 3, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    sw_left = 1'b0; push("left_run_rel", 3, 240, 1'b0, 4'b0000, 4'b1111); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sw_left = 1'b1; push("nudge", 2 - i, 240, 1'b1, (i == 2) ? 4'b0001 : 4'b0000, 4'b1111); @(negedge clk);
      sw_left = 1'b0; push("nudge_rel", 2 - i, 240, 1'b0, (i == 2) ? 4'b0001 : 4'b0000, 4'b1111); @(negedge clk);
    end
    sw_left = 1'b1;
    push("edge_left", WRAP ? 620 : 0, 240, 1'b1, WRAP ? 4'b0010 : 4'b0001, 4'b1111); @(negedge clk);
    sw_left = 1'b0;
    push("edge_left_rel", WRAP ? 620 : 0, 240, 1'b0, WRAP ? 4'b0010 : 4'b0001, 4'b1111); @(negedge clk);

    cursor_size = 2'd3; sw_right = 1'b1; recentre = 1'b1;
    push("recentre", 320, 240, 1'b0, 4'b0000, 4'b1111); @(negedge clk);
    recentre = 1'b0; push("post_recentre", 321, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    push("post_recentre2", 322, 240, 1'b1, 4'b0000, 4'b1111); @(negedge clk);
    rst_n = 1'b0; push("mid_reset", 320, 240, 1'b0, 4'b0000, 4'b1111); @(negedge clk);
    sw_right = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("scoreboard drained", q.size() + q4.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: stopped at cycle %0d, required test end first", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

endmodule
